// File: rtl/deser_pkg.sv
// Shared types and helpers for the serial-to-parallel deserializer.
package deser_pkg;

  typedef enum logic [0:0] {IDLE, SHIFT} deser_state_t;

  // Counter width able to hold 0..w.
  function automatic int cnt_w(int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/deser_shift.sv
// Shift register and bit counter; flags the qualified bit that completes a word.
module deser_shift
  import deser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1,
  localparam int CntW     = cnt_w(WIDTH)
) (
  input  logic             c,
  input  logic             rst,
  input  logic             d,
  input  logic             dValid,
  input  logic             sync,
  output logic [WIDTH-1:0] sh,
  output logic [CntW-1:0]  cnt,
  output logic             done
);

  logic [WIDTH-1:0] shNext;

  always_comb begin
    shNext = sh;
    if (MSB_FIRST != 0) shNext = {sh[WIDTH-2:0], d};
    else                shNext = {d, sh[WIDTH-1:1]};
    // A sync bit always starts a new word, so it can never complete one.
    done = dValid && !sync && (cnt == CntW'(WIDTH - 1));
  end

  always_ff @(posedge c or posedge rst) begin
    if (rst) begin
      sh  <= '0;
      cnt <= '0;
    end else if (dValid) begin
      sh <= shNext;
      if (sync)      cnt <= CntW'(1);
      else if (done) cnt <= '0;
      else           cnt <= cnt + CntW'(1);
    end else if (sync) begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/deser_always_ff.sv
// Deserializer top: word FSM, output register, valid/ready handshake, sticky overflow.
module deser_always_ff
  import deser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             c,
  input  logic             rst,
  input  logic             d,
  input  logic             d_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  input  logic             q_ready,
  output logic             overflow,
  output logic             busy
);

  // Handshake: q is transferred on any rising edge of c where q_valid=1 and
  // q_ready=1; while q_valid=1 and q_ready=0, q holds its value unchanged.

  localparam int CntW = cnt_w(WIDTH);

  deser_state_t     state;
  logic [WIDTH-1:0] sh;
  logic [CntW-1:0]  cnt;
  logic             done;
  logic [WIDTH-1:0] word;

  deser_shift #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .c      (c),
    .rst    (rst),
    .d      (d),
    .dValid (d_valid),
    .sync   (sync),
    .sh     (sh),
    .cnt    (cnt),
    .done   (done)
  );

  // The completing bit bypasses sh and is merged straight into the word.
  always_comb begin
    word = sh;
    if (MSB_FIRST != 0) word = {sh[WIDTH-2:0], d};
    else                word = {d, sh[WIDTH-1:1]};
  end

  assign busy = (state == SHIFT);

  always_ff @(posedge c or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      q        <= '0;
      q_valid  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (sync)         state <= d_valid ? SHIFT : IDLE;
      else if (d_valid) state <= done ? IDLE : SHIFT;

      if (done) begin
        if (!q_valid || q_ready) begin
          q       <= word;
          q_valid <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end else if (q_valid && q_ready) begin
        q_valid <= 1'b0;
      end
    end
  end

  // FSM and counter must always agree on whether a word is in progress.
  always_ff @(posedge c) begin
    if (!rst) assert ((state == SHIFT) == (cnt != '0));
  end

endmodule
